// File: rtl/ws2812_frame_streamer_if.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_frame_streamer_if
// Description : Control, framebuffer read and LED data signals of the streamer.
// Revision    : 1.0 - initial release
// ============================================================================
interface ws2812_frame_streamer_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic [ADDR_W-1:0] pixel_addr;
  logic [23:0]       pixel_data;
  logic              busy;
  logic              done;
  logic              dout;

  modport master (
    output start,
    output pixel_data,
    input  pixel_addr,
    input  busy,
    input  done,
    input  dout
  );

  modport slave (
    input  start,
    input  pixel_data,
    output pixel_addr,
    output busy,
    output done,
    output dout
  );
endinterface
`default_nettype wire

// File: rtl/ws2812_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_frame_streamer
// Description : Streams one frame of GRB pixels onto a WS2812 line, then latches.
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812_frame_streamer #(
  parameter int NUM_PIXELS   = 64,
  parameter int T0H          = 4,
  parameter int T1H          = 8,
  parameter int T_BIT        = 15,
  parameter int LATCH_CYCLES = 1000,
  parameter int ADDR_W       = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  wire logic             clk,
  input  wire logic             reset,
  ws2812_frame_streamer_if.slave bus
);

  localparam int CYC_W = (T_BIT > 2) ? $clog2(T_BIT) : 1;
  localparam int LAT_W = $clog2(LATCH_CYCLES + 1);

  localparam logic [CYC_W-1:0]  c_CYC_LAST  = CYC_W'(T_BIT - 1);
  localparam logic [CYC_W-1:0]  c_T0H       = CYC_W'(T0H);
  localparam logic [CYC_W-1:0]  c_T1H       = CYC_W'(T1H);
  localparam logic [LAT_W-1:0]  c_LAT_LAST  = LAT_W'(LATCH_CYCLES - 1);
  localparam logic [ADDR_W-1:0] c_ADDR_LAST = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [ADDR_W-1:0] c_ADDR_ONE  = (NUM_PIXELS == 1) ? '0 : ADDR_W'(1);
  localparam logic [4:0]        c_BIT_LAST  = 5'd23;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH0 = 3'd1,
    ST_FETCH1 = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_LATCH  = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
  logic [ADDR_W-1:0] r_pix,   w_pix_nxt;
  logic [23:0]       r_shreg, w_shreg_nxt;
  logic [CYC_W-1:0]  r_cyc,   w_cyc_nxt;
  logic [4:0]        r_bit,   w_bit_nxt;
  logic [LAT_W-1:0]  r_lat,   w_lat_nxt;
  logic              r_dout,  w_dout_nxt;
  logic              r_done,  w_done_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_pix   <= '0;
      r_shreg <= '0;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_lat   <= '0;
      r_dout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_pix   <= w_pix_nxt;
      r_shreg <= w_shreg_nxt;
      r_cyc   <= w_cyc_nxt;
      r_bit   <= w_bit_nxt;
      r_lat   <= w_lat_nxt;
      r_dout  <= w_dout_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_pix_nxt   = r_pix;
    w_shreg_nxt = r_shreg;
    w_cyc_nxt   = r_cyc;
    w_bit_nxt   = r_bit;
    w_lat_nxt   = r_lat;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_addr_nxt  = '0;
          w_state_nxt = ST_FETCH0;
        end
      end
      ST_FETCH0: begin
        w_state_nxt = ST_FETCH1;
      end
      ST_FETCH1: begin
        w_shreg_nxt = bus.pixel_data;
        w_addr_nxt  = c_ADDR_ONE;
        w_pix_nxt   = '0;
        w_bit_nxt   = '0;
        w_cyc_nxt   = '0;
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (r_cyc == c_CYC_LAST) begin
          w_cyc_nxt = '0;
          if (r_bit == c_BIT_LAST) begin
            w_bit_nxt = '0;
            if (r_pix == c_ADDR_LAST) begin
              w_addr_nxt  = '0;
              w_lat_nxt   = '0;
              w_state_nxt = ST_LATCH;
            end else begin
              // The next pixel was addressed for this whole pixel, so its data is ready now.
              w_shreg_nxt = bus.pixel_data;
              w_addr_nxt  = (r_addr == c_ADDR_LAST) ? '0 : r_addr + 1'b1;
              w_pix_nxt   = r_pix + 1'b1;
            end
          end else begin
            w_shreg_nxt = {r_shreg[22:0], 1'b0};
            w_bit_nxt   = r_bit + 1'b1;
          end
        end else begin
          w_cyc_nxt = r_cyc + 1'b1;
        end
      end
      ST_LATCH: begin
        if (r_lat == c_LAT_LAST) begin
          w_lat_nxt   = '0;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_lat_nxt = r_lat + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Computed from next-state values so the registered line tracks r_cyc exactly.
    w_dout_nxt = (w_state_nxt == ST_SHIFT) &&
                 (w_cyc_nxt < (w_shreg_nxt[23] ? c_T1H : c_T0H));
  end

  assign bus.pixel_addr = r_addr;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.done       = r_done;
  assign bus.dout       = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ws2812_frame_streamer
// Description : Self-checking bench decoding the WS2812 line against a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ws2812_frame_streamer;

  localparam int NP        = 64;
  localparam int T_BIT     = 15;
  localparam int LATCH     = 1000;
  localparam int FRAME_LEN = 2 + NP * 24 * T_BIT + LATCH;
  localparam int ABORT_OFF = 2 + 30 * 24 * T_BIT + 10 * T_BIT + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ws2812_frame_streamer_if #(.ADDR_W(6)) bus ();

  ws2812_frame_streamer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [23:0] fb [NP];
  always @(posedge clk) bus.pixel_data <= fb[bus.pixel_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  logic [23:0] got_q[$];
  logic [23:0] exp_q[$];
  int hi = 0, nbits = 0, bad_hi = 0, period_err = 0, done_cnt = 0, last_rise = 0;
  bit have_rise = 1'b0;
  logic prev_dout = 1'b0;
  logic [23:0] word = '0;

  // Line decoder: a high run of 8 cycles is a 1, 4 cycles is a 0.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        hi = 0; nbits = 0; have_rise = 1'b0; prev_dout = 1'b0;
      end else begin
        if (bus.done) done_cnt++;
        if (!bus.busy) have_rise = 1'b0;
        if (bus.dout && !prev_dout) begin
          if (have_rise && (cyc - last_rise) != T_BIT) period_err++;
          last_rise = cyc;
          have_rise = 1'b1;
        end
        if (bus.dout) hi++;
        else if (hi != 0) begin
          if (hi == 8)      word = {word[22:0], 1'b1};
          else if (hi == 4) word = {word[22:0], 1'b0};
          else              bad_hi++;
          nbits++;
          hi = 0;
          if (nbits == 24) begin
            got_q.push_back(word);
            nbits = 0;
          end
        end
        prev_dout = bus.dout;
      end
    end
  end

  task automatic kick_now(output int t0);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int t0, input int p1, input int p2,
                           output int len, output bit to);
    to = 1'b1;
    len = 0;
    for (int i = 0; i < FRAME_LEN + 100; i++) begin
      @(negedge clk);
      if (bus.done) begin
        len = cyc - t0;
        to = 1'b0;
        break;
      end
      bus.start = ((cyc - t0) == p1) || ((cyc - t0) == p2);
    end
    bus.start = 1'b0;
  endtask

  task automatic fill_solid();
    for (int i = 0; i < NP; i++) fb[i] = 24'hFF0000;
  endtask

  task automatic fill_pattern();
    logic [7:0] b;
    for (int i = 0; i < NP; i++) begin
      b = 8'(i);
      fb[i] = {b, ~b, 8'hA5};
    end
  endtask

  task automatic push_expected();
    for (int i = 0; i < NP; i++) exp_q.push_back(fb[i]);
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = {bus.dout, bus.busy, bus.done, bus.pixel_addr};
      n_total++;
      if (obs !== 9'd0) $display("FAIL reset_hold cyc=%0d got=%b want=0", i, obs);
      else n_pass++;
    end
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      obs = {bus.dout, bus.busy, bus.done, bus.pixel_addr};
      n_total++;
      if (obs !== 9'd0) $display("FAIL idle cyc=%0d got=%b want=0", i, obs);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset_mid();
    int t0, d0;
    logic [8:0] obs;
    logic [23:0] g, e;
    fill_solid();
    got_q.delete();
    exp_q.delete();
    push_expected();
    @(negedge clk);
    kick_now(t0);
    for (int i = 0; i < ABORT_OFF + 10; i++) begin
      @(negedge clk);
      if ((cyc - t0) == ABORT_OFF) break;
    end
    n_total++;
    if (bus.dout !== 1'b1) $display("FAIL abort_pre_dout got=%b want=1", bus.dout);
    else n_pass++;
    d0 = done_cnt;
    #1 reset = 1'b1;
    #1;
    obs = {bus.dout, bus.busy, bus.done, bus.pixel_addr};
    n_total++;
    if (obs !== 9'd0) $display("FAIL abort_immediate got=%b want=0", obs);
    else n_pass++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b0 || done_cnt != d0)
      $display("FAIL abort_idle busy=%b dones=%0d want busy=0 dones=%0d", bus.busy, done_cnt, d0);
    else n_pass++;
    n_total++;
    if (got_q.size() != 30) $display("FAIL abort_words got=%0d want=30", got_q.size());
    else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_total++;
      if (g !== e) $display("FAIL abort_pixel got=%h want=%h", g, e);
      else n_pass++;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_solid_frame();
    int t0, len;
    bit to;
    logic [23:0] g, e;
    bad_hi = 0;
    period_err = 0;
    push_expected();
    @(negedge clk);
    kick_now(t0);
    @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b1) $display("FAIL solid_busy got=%b want=1", bus.busy);
    else n_pass++;
    wait_done(t0, -1, -1, len, to);
    n_total++;
    if (to || len != FRAME_LEN) $display("FAIL solid_len got=%0d timeout=%0d want=%0d", len, to, FRAME_LEN);
    else n_pass++;
    n_total++;
    if (bad_hi != 0 || period_err != 0)
      $display("FAIL solid_timing bad_high=%0d bad_period=%0d want 0 0", bad_hi, period_err);
    else n_pass++;
    n_total++;
    if (got_q.size() != NP) $display("FAIL solid_words got=%0d want=%0d", got_q.size(), NP);
    else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_total++;
      if (g !== e) $display("FAIL solid_pixel got=%h want=%h", g, e);
      else n_pass++;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Entered on the negedge of the done cycle left by the previous frame.
  task automatic test_back_to_back(output int t0);
    fill_pattern();
    push_expected();
    bad_hi = 0;
    period_err = 0;
    kick_now(t0);
    @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0)
      $display("FAIL b2b_restart busy=%b done=%b want busy=1 done=0", bus.busy, bus.done);
    else n_pass++;
  endtask

  task automatic test_pattern_start_while_busy(input int t0);
    int len, d0;
    bit to;
    logic [23:0] g, e;
    d0 = done_cnt;
    wait_done(t0, 500, 20000, len, to);
    n_total++;
    if (to || len != FRAME_LEN) $display("FAIL busy_start_len got=%0d timeout=%0d want=%0d", len, to, FRAME_LEN);
    else n_pass++;
    repeat (30) @(negedge clk);
    n_total++;
    if (done_cnt != d0 + 1 || bus.busy !== 1'b0)
      $display("FAIL busy_start_dones got=%0d busy=%b want=%0d busy=0", done_cnt - d0, bus.busy, 1);
    else n_pass++;
    n_total++;
    if (bad_hi != 0 || period_err != 0)
      $display("FAIL pattern_timing bad_high=%0d bad_period=%0d want 0 0", bad_hi, period_err);
    else n_pass++;
    n_total++;
    if (got_q.size() != NP) $display("FAIL pattern_words got=%0d want=%0d", got_q.size(), NP);
    else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_total++;
      if (g !== e) $display("FAIL pattern_pixel got=%h want=%h", g, e);
      else n_pass++;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int t0;
    bus.start = 1'b0;
    fill_solid();
    test_reset();
    test_async_reset_mid();
    test_solid_frame();
    test_back_to_back(t0);
    test_pattern_start_while_busy(t0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
